// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS pixel packer.
//   PIX_W / LANES / PIX_PER_STROBE / OUT_W : pixel, lane and output geometry
//   cap_state_t   : capture FSM states
//   sideband_t    : per-word frame markers {sof, sol, eof}
//   word_entry_t  : one FIFO entry (packed word plus its sideband)
package cmos_pkg;
  localparam int PIX_W          = 10;
  localparam int LANES          = 4;
  localparam int PIX_PER_STROBE = 8;
  localparam int OUT_W          = 64;
  localparam int LANE_W         = 2 * PIX_W;
  localparam int STROBE_W       = PIX_PER_STROBE * PIX_W;   // 80 bits per strobe
  localparam int ACC_W          = OUT_W + STROBE_W;         // 144-bit gearbox
  localparam int FILL_W         = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_STROBE,
    ST_CAPTURE
  } cap_state_t;

  typedef struct packed {
    logic sof;
    logic sol;
    logic eof;
  } sideband_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    sideband_t        sb;
  } word_entry_t;
endpackage

// File: rtl/cmos_word_fifo.sv
// Synchronous FIFO of packed output words (64 data bits + 3 sideband bits).
//   clk_input, reset      : clock, asynchronous active-high reset
//   wr_en, wr_entry       : write request; accepted when not full or when a
//                           read happens in the same cycle
//   full, empty           : occupancy flags
//   rd_ready, rd_entry    : read port; data is valid whenever !empty and reads
//                           zero while empty
module cmos_word_fifo
  import cmos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_input,
  input  logic        reset,
  input  logic        wr_en,
  input  word_entry_t wr_entry,
  output logic        full,
  output logic        empty,
  input  logic        rd_ready,
  output word_entry_t rd_entry
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_fire, rd_fire;
  word_entry_t   mem_q [DEPTH];

  // NOTE: every signal written in always_comb gets a value before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_fire  = !empty && rd_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    wr_fire  = wr_en && (!full || rd_ready);
    wr_ptr_d = wr_ptr_q + PW'(wr_fire);
    rd_ptr_d = rd_ptr_q + PW'(rd_fire);
    rd_entry = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in the pointers and
  // the read port is masked while empty, so stale contents are never seen.
  always_ff @(posedge clk_input) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end
endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs 4-lane deserializer words (8 x 10-bit pixels per strobe) into 64-bit
// words with frame/line markers, behind a small FIFO.
//   clk_input, reset          : sole clock, asynchronous active-high reset
//   channel_0..3_data, frame  : lane words, valid in the one-cycle strobe
//   capture_en                : level request to capture one frame
//   out_data/out_valid/out_ready, out_sof/out_sol/out_eof : output stream
//   busy, frame_done, overflow : capture status (overflow is sticky)
// Build option: CMOS_TEST_PATTERN_EN replaces each pixel with its index within
// the line (mod 1024); timing and sideband are unchanged.
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 2048,
  parameter int LINES_PER_FRAME = 2048,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk_input,
  input  logic              reset,
  input  logic [LANE_W-1:0] channel_0_data,
  input  logic [LANE_W-1:0] channel_1_data,
  input  logic [LANE_W-1:0] channel_2_data,
  input  logic [LANE_W-1:0] channel_3_data,
  input  logic              frame,
  input  logic              capture_en,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_sol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam int PIX_CW         = $clog2(PIXELS_PER_LINE);
  localparam int LINE_CW        = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  // Every 32 pixels (4 strobes) yield exactly 5 words, so lines end word-aligned.
  localparam int WORDS_PER_LINE = PIXELS_PER_LINE / 32 * 5;
  localparam int WORD_CW        = $clog2(WORDS_PER_LINE);

  cap_state_t         state_q, state_d;
  logic [PIX_CW-1:0]  pix_q, pix_d;        // first pixel of the next strobe
  logic [LINE_CW-1:0] line_q, line_d;
  logic               take, start, last_pix, last_line;

  logic [LANE_W-1:0]   lane_word [LANES];
  logic [PIX_W-1:0]    pix [PIX_PER_STROBE];
  logic [STROBE_W-1:0] strobe_bits;

  logic [ACC_W-1:0]   acc_q, acc_d, acc_shift;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_shift;
  logic               emit, drop;
  logic [WORD_CW-1:0] word_q, word_d;      // word index within the line
  logic [LINE_CW-1:0] wline_q, wline_d;    // line index of the emitted word
  sideband_t          emit_sb;
  word_entry_t        wr_entry, rd_entry;
  logic               fifo_full, fifo_empty;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  // Capture FSM and position counters.
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    take      = 1'b0;
    start     = 1'b0;
    last_pix  = (pix_q == PIX_CW'(PIXELS_PER_LINE - PIX_PER_STROBE));
    last_line = (line_q == LINE_CW'(LINES_PER_FRAME - 1));
    case (state_q)
      ST_IDLE: begin
        if (capture_en) state_d = ST_WAIT_STROBE;
      end
      ST_WAIT_STROBE: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end else if (frame) begin
          // This strobe is pixel 0 of line 0; counters restart past it.
          state_d = ST_CAPTURE;
          take    = 1'b1;
          start   = 1'b1;
          pix_d   = PIX_CW'(PIX_PER_STROBE);
          line_d  = '0;
        end
      end
      ST_CAPTURE: begin
        if (frame) begin
          take = 1'b1;
          if (last_pix) begin
            pix_d = '0;
            if (last_line) state_d = ST_IDLE;
            else           line_d  = line_q + LINE_CW'(1);
          end else begin
            pix_d = pix_q + PIX_CW'(PIX_PER_STROBE);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CMOS_TEST_PATTERN_EN
  logic [PIX_CW-1:0] pix_base;
  assign pix_base = start ? '0 : pix_q;
`endif

  // Lane slicing: p0..p3 from the upper halves, p4..p7 from the lower halves.
  always_comb begin
    lane_word[0] = channel_0_data;
    lane_word[1] = channel_1_data;
    lane_word[2] = channel_2_data;
    lane_word[3] = channel_3_data;
    strobe_bits  = '0;
    for (int i = 0; i < LANES; i++) begin
      pix[i]         = lane_word[i][LANE_W-1:PIX_W];
      pix[i + LANES] = lane_word[i][PIX_W-1:0];
    end
`ifdef CMOS_TEST_PATTERN_EN
    for (int k = 0; k < PIX_PER_STROBE; k++) begin
      pix[k] = PIX_W'(pix_base) + PIX_W'(k);
    end
`endif
    for (int k = 0; k < PIX_PER_STROBE; k++) begin
      strobe_bits[k*PIX_W +: PIX_W] = pix[k];
    end
  end

  // Gearbox, word sideband and status flags.
  always_comb begin
    // At most one word leaves per cycle; a new strobe lands above what remains.
    emit       = (fill_q >= FILL_W'(OUT_W));
    acc_shift  = emit ? (acc_q >> OUT_W) : acc_q;
    fill_shift = emit ? (fill_q - FILL_W'(OUT_W)) : fill_q;
    acc_d      = acc_shift;
    fill_d     = fill_shift;
    if (take) begin
      acc_d  = acc_shift | (ACC_W'(strobe_bits) << fill_shift);
      fill_d = fill_shift + FILL_W'(STROBE_W);
    end

    emit_sb.sol = (word_q == '0);
    emit_sb.sof = emit_sb.sol && (wline_q == '0);
    emit_sb.eof = (word_q == WORD_CW'(WORDS_PER_LINE - 1)) &&
                  (wline_q == LINE_CW'(LINES_PER_FRAME - 1));
    wr_entry    = '{data: acc_q[OUT_W-1:0], sb: emit_sb};

    word_d  = word_q;
    wline_d = wline_q;
    if (emit) begin
      if (word_q == WORD_CW'(WORDS_PER_LINE - 1)) begin
        word_d  = '0;
        wline_d = emit_sb.eof ? '0 : wline_q + LINE_CW'(1);
      end else begin
        word_d = word_q + WORD_CW'(1);
      end
    end
    if (start) begin
      word_d  = '0;
      wline_d = '0;
    end

    // A dropped word still advances the word position, keeping markers aligned.
    drop       = emit && fifo_full && !out_ready;
    overflow_d = overflow_q;
    if (start) overflow_d = 1'b0;
    if (drop)  overflow_d = 1'b1;

    // The frame ends when its last word is offered to the FIFO.
    frame_done_d = emit && emit_sb.eof;
    busy_d       = busy_q;
    if (frame_done_d) busy_d = 1'b0;
    if (start)        busy_d = 1'b1;
  end

  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pix_q        <= '0;
      line_q       <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      word_q       <= '0;
      wline_q      <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      word_q       <= word_d;
      wline_q      <= wline_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  cmos_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_input (clk_input),
    .reset     (reset),
    .wr_en     (emit),
    .wr_entry  (wr_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_ready  (out_ready),
    .rd_entry  (rd_entry)
  );

  assign out_data   = rd_entry.data;
  assign out_sof    = rd_entry.sb.sof;
  assign out_sol    = rd_entry.sb.sol;
  assign out_eof    = rd_entry.sb.eof;
  assign out_valid  = !fifo_empty;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer: a bit-stream model of the pixel
// stream queues expected words at each strobe; a monitor pops and compares
// them whenever the DUT hands a word over.
module tb_cmos_pixel_packer;
  localparam int PPL   = 32;
  localparam int LPF   = 2;
  localparam int DEPTH = 4;
  localparam int WPL   = PPL / 32 * 5;
  localparam int WPF   = WPL * LPF;
  localparam int SPF   = PPL / 8 * LPF;     // strobes per frame

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ch0, ch1, ch2, ch3;
  logic        frame, capture_en, out_ready;
  logic [63:0] out_data;
  logic        out_valid, out_sof, out_sol, out_eof;
  logic        busy, frame_done, overflow;

  cmos_pixel_packer #(
    .PIXELS_PER_LINE (PPL),
    .LINES_PER_FRAME (LPF),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_input      (clk),
    .reset          (reset),
    .channel_0_data (ch0),
    .channel_1_data (ch1),
    .channel_2_data (ch2),
    .channel_3_data (ch3),
    .frame          (frame),
    .capture_en     (capture_en),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sof        (out_sof),
    .out_sol        (out_sol),
    .out_eof        (out_eof),
    .busy           (busy),
    .frame_done     (frame_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  sb;      // {sof, sol, eof}
  } exp_t;

  exp_t        exp_q[$];
  bit          mbits[$];
  int          m_word;
  int          m_limit;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [63:0] sof_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] stim_word(input int fid, input int s, input int l);
    return {4'(l + 1), 8'(s * 17 + 3), 8'(fid * 29 + 5)};
  endfunction

  // Reference: pixels form a little-endian bit stream cut into 64-bit words.
  task automatic model_strobe(input logic [19:0] c0, c1, c2, c3, input int pix_base);
    logic [9:0]  p [8];
    logic [63:0] w;
    exp_t        e;
    p[0] = c0[19:10]; p[1] = c1[19:10]; p[2] = c2[19:10]; p[3] = c3[19:10];
    p[4] = c0[9:0];   p[5] = c1[9:0];   p[6] = c2[9:0];   p[7] = c3[9:0];
`ifdef CMOS_TEST_PATTERN_EN
    for (int k = 0; k < 8; k++) p[k] = 10'(pix_base + k);
`endif
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 10; b++) mbits.push_back(p[k][b]);
    while (mbits.size() >= 64) begin
      for (int b = 0; b < 64; b++) w[b] = mbits.pop_front();
      e.data = w;
      e.sb   = {m_word == 0, (m_word % WPL) == 0, m_word == WPF - 1};
      if (m_word < m_limit) exp_q.push_back(e);
      m_word++;
    end
  endtask

  // One strobe; strobes are issued every 5 clock cycles.
  task automatic strobe(input logic [19:0] c0, c1, c2, c3, input bit do_model, input int pix_base);
    @(posedge clk); #1;
    frame = 1'b1; ch0 = c0; ch1 = c1; ch2 = c2; ch3 = c3;
    if (do_model) model_strobe(c0, c1, c2, c3, pix_base);
    @(posedge clk); #1;
    frame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int fid, input int n_strobes, input bit do_model,
                           input int limit, input bit lane_map, input bit drop_en,
                           input bit ovf_checks);
    logic [19:0] c [4];
    m_word  = 0;
    m_limit = limit;
    mbits.delete();
    for (int s = 0; s < n_strobes; s++) begin
      for (int l = 0; l < 4; l++) c[l] = stim_word(fid, s, l);
      if (lane_map && s == 0) begin
        c[0] = 20'h00001; c[1] = '0; c[2] = '0; c[3] = '0;
      end
      strobe(c[0], c[1], c[2], c[3], do_model, (s * 8) % PPL);
      if (s == 0 && drop_en) capture_en = 1'b0;
      if (ovf_checks && s == 2) check("overflow_before_5th_word", 64'(overflow), 64'd0);
      if (ovf_checks && s == 3) check("overflow_after_5th_word", 64'(overflow), 64'd1);
    end
  endtask

  // Monitor: compares every handed-over word against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) n_done++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %h sb=%b, expected no word (t=%0t)",
                 out_data, {out_sof, out_sol, out_eof}, $time);
      end else begin
        e = exp_q.pop_front();
        check("word_data", out_data, e.data);
        check("word_sideband", 64'({out_sof, out_sol, out_eof}), 64'(e.sb));
        if (out_sof) sof_data = out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    logic [9:0] lane_exp;
    reset = 1'b1; frame = 1'b0; capture_en = 1'b0; out_ready = 1'b1;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_sideband", 64'({out_sof, out_sol, out_eof}), 64'd0);
    check("reset_status", 64'({busy, frame_done, overflow}), 64'd0);
    reset = 1'b0;

    // Strobes without capture_en are ignored.
    for (int s = 0; s < 3; s++) strobe(stim_word(9, s, 0), stim_word(9, s, 1),
                                       stim_word(9, s, 2), stim_word(9, s, 3), 1'b0, 0);
    check("gated_busy", 64'(busy), 64'd0);
    check("gated_no_words", 64'(out_valid), 64'd0);

    // Raise capture_en mid-stream; two frames back-to-back, lane mapping first.
    capture_en = 1'b1;
    run_frame(1, 1, 1'b1, WPF, 1'b1, 1'b0, 1'b0);
`ifdef CMOS_TEST_PATTERN_EN
    lane_exp = 10'd4;
`else
    lane_exp = 10'd1;
`endif
    check("lane_map_p4", 64'(sof_data[49:40]), 64'(lane_exp));
    check("busy_in_frame", 64'(busy), 64'd1);
    // Rest of frame 1 continues the same model stream.
    for (int s = 1; s < SPF; s++)
      strobe(stim_word(1, s, 0), stim_word(1, s, 1), stim_word(1, s, 2),
             stim_word(1, s, 3), 1'b1, (s * 8) % PPL);
    run_frame(2, SPF, 1'b1, WPF, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("two_frames_done", 64'(n_done), 64'd2);
    check("two_frames_drained", 64'(exp_q.size()), 64'd0);
    check("two_frames_busy", 64'(busy), 64'd0);
    check("two_frames_overflow", 64'(overflow), 64'd0);

    // Backpressure: only the first DEPTH words survive.
    out_ready  = 1'b0;
    capture_en = 1'b1;
    run_frame(3, SPF, 1'b1, DEPTH, 1'b0, 1'b1, 1'b1);
    check("bp_valid_held", 64'(out_valid), 64'd1);
    check("bp_overflow_sticky", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_empty_after", 64'(out_valid), 64'd0);

    // Reset in the middle of line 1 with a full FIFO.
    out_ready  = 1'b0;
    capture_en = 1'b1;
    run_frame(4, SPF - 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_overflow", 64'(overflow), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_overflow", 64'(overflow), 64'd0);
    check("mid_reset_data", out_data, 64'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;

    // Clean restart.
    done_before = n_done;
    capture_en  = 1'b1;
    run_frame(5, SPF, 1'b1, WPF, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("restart_done_pulse", 64'(n_done - done_before), 64'd1);
    check("restart_drained", 64'(exp_q.size()), 64'd0);
    check("restart_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
